// File: rtl/data_mem_responder_if.sv
// Processor data port plus the TX output stream of the data-side memory responder.
// The processor (or bench) drives through master; the responder attaches as slave.
interface data_mem_responder_if;
    logic        WE;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output WE, address_to_mem, data_to_mem, tx_ready,
        input  data_from_mem, tx_data, tx_valid
    );

    modport slave (
        input  WE, address_to_mem, data_to_mem, tx_ready,
        output data_from_mem, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM, TX FIFO stream, STATUS and CYCLE registers.
// Reads are combinational; every write commits on the rising edge of clk.
module data_mem_responder #(
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [29:0] TXDATA_WORD = 30'h3FFF_FFC0;
    localparam logic [29:0] STATUS_WORD = 30'h3FFF_FFC1;
    localparam logic [29:0] CYCLE_WORD  = 30'h3FFF_FFC2;

    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          ovf, bad;
    logic [31:0]   cycle;

    logic          ram_sel, tx_sel, status_sel, cycle_sel, unmapped;
    logic [AW-1:0] ram_idx;
    logic          empty, full, pop, push_req, push_ok;

    // Byte offset bits never take part in decode.
    wire unused_addr_lsbs = &{1'b0, bus.address_to_mem[1:0]};

    assign ram_sel    = (bus.address_to_mem[31:AW+2] == '0);
    assign tx_sel     = (bus.address_to_mem[31:2] == TXDATA_WORD);
    assign status_sel = (bus.address_to_mem[31:2] == STATUS_WORD);
    assign cycle_sel  = (bus.address_to_mem[31:2] == CYCLE_WORD);
    assign unmapped   = !(ram_sel || tx_sel || status_sel || cycle_sel);
    assign ram_idx    = bus.address_to_mem[AW+1:2];

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = bus.WE && tx_sel;
    // A pop in the same edge frees the slot the push lands in, so a full FIFO still accepts.
    assign push_ok  = push_req && (!full || pop);

    // NOTE: storage arrays carry no reset; only control state is cleared, so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus.WE && ram_sel)
            ram[ram_idx] <= bus.data_to_mem;
        if (push_ok)
            fifo_mem[wr_ptr] <= bus.data_to_mem;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            bad    <= 1'b0;
            cycle  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !push_ok)
                count <= count - CW'(1);

            // Set and clear sources for each flag are different addresses, so they never collide.
            if (bus.WE && status_sel && bus.data_to_mem[31])
                ovf <= 1'b0;
            else if (push_req && !push_ok)
                ovf <= 1'b1;

            if (bus.WE && status_sel && bus.data_to_mem[30])
                bad <= 1'b0;
            else if (bus.WE && unmapped)
                bad <= 1'b1;

            if (bus.WE && cycle_sel)
                cycle <= bus.data_to_mem;
            else
                cycle <= cycle + 32'd1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bus.data_from_mem = '0;
        if (ram_sel)
            bus.data_from_mem = ram[ram_idx];
        else if (status_sel)
            bus.data_from_mem = {ovf, bad, 12'b0, full, empty, 16'(count)};
        else if (cycle_sel)
            bus.data_from_mem = cycle;
    end

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 32'd0 : fifo_mem[rd_ptr];
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: RAM, TX FIFO, STATUS, CYCLE, reset.
module tb_data_mem_responder;
    localparam logic [31:0] TXDATA = 32'hFFFF_FF00;
    localparam logic [31:0] STATUS = 32'hFFFF_FF04;
    localparam logic [31:0] CYCLE  = 32'hFFFF_FF08;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_bad = 0;

    data_mem_responder_if bus ();

    data_mem_responder #(.MEM_WORDS(256), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One write committed at the next rising edge; returns just after that edge.
    task automatic write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.WE = 1'b1;
        bus.address_to_mem = addr;
        bus.data_to_mem = data;
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
    endtask

    // Combinational read in the current cycle, no clock edge consumed.
    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.WE = 1'b0;
        bus.address_to_mem = addr;
        #1;
        check(tag, bus.data_from_mem, exp);
    endtask

    initial begin
        bus.WE = 1'b0;
        bus.address_to_mem = '0;
        bus.data_to_mem = '0;
        bus.tx_ready = 1'b0;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", bus.tx_data, 32'd0);
        read_check("rst_status", STATUS, 32'h0001_0000);
        read_check("rst_cycle", CYCLE, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // RAM write/read, byte offset ignored.
        write(32'h10, 32'hDEAD_BEEF);
        read_check("ram_0x10", 32'h10, 32'hDEAD_BEEF);
        read_check("ram_0x13", 32'h13, 32'hDEAD_BEEF);
        read_check("txdata_read", TXDATA, 32'd0);

        // Fill, overflow, drain.
        for (int i = 0; i < 8; i++)
            write(TXDATA, 32'h11 + 32'(i));
        read_check("fill_status", STATUS, 32'h0002_0008);
        write(TXDATA, 32'h99);
        read_check("ovf_status", STATUS, 32'h8002_0008);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(bus.tx_valid), 32'd1);
            check("drain_data", bus.tx_data, 32'h11 + 32'(i));
            @(posedge clk);
            #1;
        end
        bus.tx_ready = 1'b0;
        check("drain_empty_valid", 32'(bus.tx_valid), 32'd0);
        check("drain_empty_data", bus.tx_data, 32'd0);
        write(STATUS, 32'h8000_0000);
        read_check("ovf_clear", STATUS, 32'h0001_0000);

        // Push into a full FIFO while popping in the same edge.
        for (int i = 0; i < 8; i++)
            write(TXDATA, 32'h21 + 32'(i));
        bus.tx_ready = 1'b1;
        write(TXDATA, 32'hAA);
        bus.tx_ready = 1'b0;
        read_check("pushpop_status", STATUS, 32'h0002_0008);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pushpop_data", bus.tx_data, (i < 7) ? 32'h22 + 32'(i) : 32'hAA);
            @(posedge clk);
            #1;
        end
        bus.tx_ready = 1'b0;
        check("pushpop_empty", 32'(bus.tx_valid), 32'd0);

        // CYCLE load and wrap over consecutive cycles.
        write(CYCLE, 32'hFFFF_FFFE);
        read_check("cycle_load", CYCLE, 32'hFFFF_FFFE);
        @(posedge clk);
        read_check("cycle_inc", CYCLE, 32'hFFFF_FFFF);
        @(posedge clk);
        read_check("cycle_wrap", CYCLE, 32'h0000_0000);

        // Unmapped access and flag clearing.
        write(32'h0000_8000, 32'h1234_5678);
        read_check("unmapped_read", 32'h0000_8000, 32'd0);
        read_check("bad_status", STATUS, 32'h4001_0000);
        write(TXDATA, 32'h5A);
        for (int i = 0; i < 8; i++)
            write(TXDATA, 32'h60 + 32'(i));
        read_check("both_flags", STATUS, 32'hC002_0008);
        write(STATUS, 32'hC000_0000);
        read_check("flags_clear", STATUS, 32'h0002_0008);
        bus.tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
        check("flush_empty", 32'(bus.tx_valid), 32'd0);

        // Reset mid-transfer.
        for (int i = 0; i < 3; i++)
            write(TXDATA, 32'h31 + 32'(i));
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
        check("midpop_head", bus.tx_data, 32'h32);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.tx_valid), 32'd0);
        check("midrst_data", bus.tx_data, 32'd0);
        read_check("midrst_status", STATUS, 32'h0001_0000);
        read_check("midrst_cycle", CYCLE, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        read_check("ram_kept", 32'h10, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
